// File: rtl/frac_scan.sv
// Walks an H_RES x V_RES pixel grid, hands each coordinate to the fractal engine via go/done,
// and writes the found flag out over valid/ready. Cost per pixel: engine latency + 3; a stalled write blocks the next request.
module frac_scan #(
  parameter int N      = 32,
  parameter int M      = 4,
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int ADDR_W = 19
) (
  input  logic              frac_clk,
  input  logic              frac_rst_n,
  input  logic              scan_start,
  input  logic [N-1:0]      scan_cx_min,
  input  logic [N-1:0]      scan_cy_max,
  input  logic [N-1:0]      scan_step,
  input  logic [15:0]       scan_max_iter,
  output logic              scan_busy,
  output logic              scan_frame_done,
  output logic [N-1:0]      frac_cx,
  output logic [N-1:0]      frac_cy,
  output logic [15:0]       frac_max_iter,
  output logic              frac_go,
  input  logic              frac_done,
  input  logic              frac_found,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [ADDR_W-1:0] pix_addr,
  output logic              pix_data
);

  localparam int CW = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int RW = (V_RES > 1) ? $clog2(V_RES) : 1;

  generate
    if (M < 1 || M >= N || longint'(H_RES) * longint'(V_RES) > (longint'(1) << ADDR_W)) begin : g_bad_param
      $error("frac_scan: inconsistent parameters");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WRITE} state_t;

  state_t            state_q, state_d;
  logic [N-1:0]      cx_min_q, cx_min_d;
  logic [N-1:0]      step_q, step_d;
  logic              first_q, first_d;
  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic [ADDR_W-1:0] addr_d;
  logic [N-1:0]      cx_d, cy_d;
  logic [15:0]       mi_d;
  logic              busy_d, fdone_d, go_d, valid_d, data_d;

  always_ff @(posedge frac_clk) begin
    if (!frac_rst_n) begin
      state_q         <= IDLE;
      cx_min_q        <= '0;
      step_q          <= '0;
      first_q         <= 1'b0;
      col_q           <= '0;
      row_q           <= '0;
      pix_addr        <= '0;
      frac_cx         <= '0;
      frac_cy         <= '0;
      frac_max_iter   <= 16'd1;
      scan_busy       <= 1'b0;
      scan_frame_done <= 1'b0;
      frac_go         <= 1'b0;
      pix_valid       <= 1'b0;
      pix_data        <= 1'b0;
    end else begin
      state_q         <= state_d;
      cx_min_q        <= cx_min_d;
      step_q          <= step_d;
      first_q         <= first_d;
      col_q           <= col_d;
      row_q           <= row_d;
      pix_addr        <= addr_d;
      frac_cx         <= cx_d;
      frac_cy         <= cy_d;
      frac_max_iter   <= mi_d;
      scan_busy       <= busy_d;
      scan_frame_done <= fdone_d;
      frac_go         <= go_d;
      pix_valid       <= valid_d;
      pix_data        <= data_d;
    end
  end

  // Every output is a register; this block computes their next values.
  always_comb begin
    state_d  = state_q;
    cx_min_d = cx_min_q;
    step_d   = step_q;
    first_d  = 1'b0;
    col_d    = col_q;
    row_d    = row_q;
    addr_d   = pix_addr;
    cx_d     = frac_cx;
    cy_d     = frac_cy;
    mi_d     = frac_max_iter;
    busy_d   = scan_busy;
    fdone_d  = 1'b0;
    go_d     = 1'b0;
    valid_d  = pix_valid;
    data_d   = pix_data;
    case (state_q)
      IDLE: begin
        if (scan_start) begin
          cx_min_d = scan_cx_min;
          step_d   = scan_step;
          mi_d     = (scan_max_iter == 16'd0) ? 16'd1 : scan_max_iter;
          col_d    = '0;
          row_d    = '0;
          addr_d   = '0;
          cx_d     = scan_cx_min;
          cy_d     = scan_cy_max;
          busy_d   = 1'b1;
          go_d     = 1'b1;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        first_d = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        // The engine's done from the previous pixel is still up in the first WAIT cycle.
        if (!first_q && frac_done) begin
          data_d  = frac_found;
          valid_d = 1'b1;
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (pix_ready) begin
          valid_d = 1'b0;
          if (col_q == CW'(H_RES - 1) && row_q == RW'(V_RES - 1)) begin
            fdone_d = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            if (col_q == CW'(H_RES - 1)) begin
              col_d = '0;
              row_d = row_q + RW'(1);
              cx_d  = cx_min_q;
              cy_d  = frac_cy - step_q;
            end else begin
              col_d = col_q + CW'(1);
              cx_d  = frac_cx + step_q;
            end
            addr_d  = pix_addr + ADDR_W'(1);
            go_d    = 1'b1;
            state_d = ISSUE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_frac_scan.sv
// Directed bench for frac_scan on a 4x2 grid with a behavioural engine of programmable latency.
module tb_frac_scan;

  localparam int TH = 4;
  localparam int TV = 2;
  localparam int TA = 3;
  localparam int NPIX = TH * TV;

  logic          frac_clk = 1'b0;
  logic          frac_rst_n = 1'b0;
  logic          scan_start = 1'b0;
  logic [31:0]   scan_cx_min = '0, scan_cy_max = '0, scan_step = '0;
  logic [15:0]   scan_max_iter = '0;
  logic          scan_busy, scan_frame_done, frac_go, pix_valid, pix_data;
  logic [31:0]   frac_cx, frac_cy;
  logic [15:0]   frac_max_iter;
  logic          frac_done, frac_found;
  logic          pix_ready = 1'b1;
  logic [TA-1:0] pix_addr;

  frac_scan #(.N(32), .M(4), .H_RES(TH), .V_RES(TV), .ADDR_W(TA)) dut (
    .frac_clk(frac_clk), .frac_rst_n(frac_rst_n), .scan_start(scan_start),
    .scan_cx_min(scan_cx_min), .scan_cy_max(scan_cy_max), .scan_step(scan_step),
    .scan_max_iter(scan_max_iter), .scan_busy(scan_busy), .scan_frame_done(scan_frame_done),
    .frac_cx(frac_cx), .frac_cy(frac_cy), .frac_max_iter(frac_max_iter), .frac_go(frac_go),
    .frac_done(frac_done), .frac_found(frac_found), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .pix_addr(pix_addr), .pix_data(pix_data)
  );

  always #5 frac_clk = ~frac_clk;

  // Engine: done stays high until the cycle after the next go is sampled.
  int       eng_lat = 5;
  logic [7:0] eng_pat = 8'hFF;
  int       eng_cnt, eng_idx, eng_cur;
  always @(posedge frac_clk) begin
    if (!frac_rst_n) begin
      frac_done <= 1'b0; frac_found <= 1'b0; eng_cnt <= 0; eng_idx <= 0; eng_cur <= 0;
    end else if (frac_go) begin
      eng_cnt <= eng_lat; eng_cur <= eng_idx; eng_idx <= eng_idx + 1;
    end else if (eng_cnt > 1) begin
      frac_done <= 1'b0; eng_cnt <= eng_cnt - 1;
    end else if (eng_cnt == 1) begin
      frac_done <= 1'b1; frac_found <= eng_pat[eng_cur[2:0]]; eng_cnt <= 0;
    end
  end

  // Monitor and pix_ready driver, all on the falling edge.
  logic [31:0]   go_cx[$], go_cy[$];
  logic [15:0]   go_mi[$];
  logic [TA-1:0] wr_addr[$];
  logic          wr_data[$];
  int stall_addr = 3, stall_len = 0;
  int stall_seen, done_cnt, go_while_valid, go_late, coord_err, hold_err, gap_min, gap_max, since;
  logic in_pix, prev_valid, acc_nf_prev;
  logic [31:0] cx_cap, cy_cap;
  logic [15:0] mi_cap;
  logic [TA-1:0] hold_addr;
  logic hold_data;

  always @(negedge frac_clk) begin
    if (!frac_rst_n) begin
      in_pix = 1'b0; prev_valid = 1'b0; acc_nf_prev = 1'b0; pix_ready = 1'b1;
    end else begin
      if (scan_start && !scan_busy) begin
        go_cx.delete(); go_cy.delete(); go_mi.delete(); wr_addr.delete(); wr_data.delete();
        stall_seen = 0; done_cnt = 0; go_while_valid = 0; go_late = 0; coord_err = 0;
        hold_err = 0; gap_min = 9999; gap_max = 0; since = 0;
        in_pix = 1'b0; prev_valid = 1'b0; acc_nf_prev = 1'b0;
      end
      if (pix_valid && int'(pix_addr) == stall_addr && stall_seen < stall_len) begin
        pix_ready = 1'b0; stall_seen++;
      end else begin
        pix_ready = 1'b1;
      end
      if (acc_nf_prev && !frac_go) go_late++;
      if (frac_go) begin
        go_cx.push_back(frac_cx); go_cy.push_back(frac_cy); go_mi.push_back(frac_max_iter);
        cx_cap = frac_cx; cy_cap = frac_cy; mi_cap = frac_max_iter;
        since = 0; in_pix = 1'b1;
        if (pix_valid) go_while_valid++;
      end else begin
        since++;
        if (in_pix && (frac_cx !== cx_cap || frac_cy !== cy_cap || frac_max_iter !== mi_cap))
          coord_err++;
      end
      if (pix_valid && !prev_valid) begin
        if (since < gap_min) gap_min = since;
        if (since > gap_max) gap_max = since;
        hold_addr = pix_addr; hold_data = pix_data;
      end else if (pix_valid && (pix_addr !== hold_addr || pix_data !== hold_data)) begin
        hold_err++;
      end
      acc_nf_prev = 1'b0;
      if (pix_valid && pix_ready) begin
        wr_addr.push_back(pix_addr); wr_data.push_back(pix_data); in_pix = 1'b0;
        acc_nf_prev = (int'(pix_addr) != NPIX - 1);
      end
      if (scan_frame_done) done_cnt++;
      prev_valid = pix_valid;
    end
  end

  int n_assert = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string p);
    check({p, "_busy"},  32'(scan_busy), 32'd0);
    check({p, "_fdone"}, 32'(scan_frame_done), 32'd0);
    check({p, "_go"},    32'(frac_go), 32'd0);
    check({p, "_valid"}, 32'(pix_valid), 32'd0);
    check({p, "_data"},  32'(pix_data), 32'd0);
    check({p, "_addr"},  32'(pix_addr), 32'd0);
    check({p, "_cx"},    frac_cx, 32'd0);
    check({p, "_cy"},    frac_cy, 32'd0);
    check({p, "_maxit"}, 32'(frac_max_iter), 32'd1);
  endtask

  task automatic start(input logic [31:0] cx, input logic [31:0] cy, input logic [31:0] st,
                       input logic [15:0] mi);
    @(posedge frac_clk); #1;
    scan_cx_min = cx; scan_cy_max = cy; scan_step = st; scan_max_iter = mi; scan_start = 1'b1;
    @(posedge frac_clk); #1;
    scan_start = 1'b0;
  endtask

  task automatic wait_frame(input string p, input int budget);
    int k = 0;
    while (done_cnt == 0 && k < budget) begin
      @(negedge frac_clk); k++;
    end
    check({p, "_done_seen"}, 32'(done_cnt != 0), 32'd1);
    repeat (3) @(negedge frac_clk);
    check({p, "_done_pulses"}, 32'(done_cnt), 32'd1);
    check({p, "_busy_after"}, 32'(scan_busy), 32'd0);
  endtask

  initial begin
    logic [31:0] exp_cx, exp_cy;
    int k;

    // Reset values
    repeat (3) @(posedge frac_clk);
    #1 frac_rst_n = 1'b1;
    @(negedge frac_clk);
    check_reset("rst0");

    // Frame A: latency 5, always found, pixel 3 stalled 7 cycles
    eng_lat = 5; eng_pat = 8'hFF; stall_addr = 3; stall_len = 7;
    start(32'hE000_0000, 32'h0800_0000, 32'h0100_0000, 16'd100);
    wait_frame("A", 400);
    check("A_nwr", 32'(wr_addr.size()), 32'(NPIX));
    check("A_ngo", 32'(go_cx.size()), 32'(NPIX));
    for (int i = 0; i < NPIX; i++) begin
      exp_cx = 32'hE000_0000 + 32'(i % TH) * 32'h0100_0000;
      exp_cy = (i < TH) ? 32'h0800_0000 : 32'h0700_0000;
      check($sformatf("A_addr%0d", i), 32'(wr_addr[i]), 32'(i));
      check($sformatf("A_data%0d", i), 32'(wr_data[i]), 32'd1);
      check($sformatf("A_cx%0d", i), go_cx[i], exp_cx);
      check($sformatf("A_cy%0d", i), go_cy[i], exp_cy);
      check($sformatf("A_mi%0d", i), 32'(go_mi[i]), 32'd100);
    end
    check("A_stall_cycles", 32'(stall_seen), 32'd7);
    check("A_hold_err", 32'(hold_err), 32'd0);
    check("A_go_while_valid", 32'(go_while_valid), 32'd0);
    check("A_go_late", 32'(go_late), 32'd0);
    check("A_coord_err", 32'(coord_err), 32'd0);
    check("A_gap_min", 32'(gap_min), 32'd7);
    check("A_gap_max", 32'(gap_max), 32'd7);

    // Frame B: done held high (stale), wrap, max_iter clamp, start while busy ignored
    eng_lat = 1; eng_pat = 8'b1011_0010; stall_len = 0;
    start(32'h7F00_0000, 32'h0000_0000, 32'h0100_0000, 16'd0);
    repeat (10) @(negedge frac_clk);
    check("B_busy_mid", 32'(scan_busy), 32'd1);
    start(32'h1111_1111, 32'h2222_2222, 32'h0300_0000, 16'd5);
    wait_frame("B", 400);
    check("B_nwr", 32'(wr_addr.size()), 32'(NPIX));
    check("B_ngo", 32'(go_cx.size()), 32'(NPIX));
    check("B_wrap_cx1", go_cx[1], 32'h8000_0000);
    for (int i = 0; i < NPIX; i++) begin
      exp_cx = 32'h7F00_0000 + 32'(i % TH) * 32'h0100_0000;
      exp_cy = (i < TH) ? 32'h0000_0000 : 32'hFF00_0000;
      check($sformatf("B_addr%0d", i), 32'(wr_addr[i]), 32'(i));
      check($sformatf("B_data%0d", i), 32'(wr_data[i]), 32'(eng_pat[i]));
      check($sformatf("B_cx%0d", i), go_cx[i], exp_cx);
      check($sformatf("B_cy%0d", i), go_cy[i], exp_cy);
      check($sformatf("B_mi%0d", i), 32'(go_mi[i]), 32'd1);
    end
    check("B_gap_min", 32'(gap_min), 32'd3);
    check("B_gap_max", 32'(gap_max), 32'd3);
    check("B_go_late", 32'(go_late), 32'd0);
    check("B_coord_err", 32'(coord_err), 32'd0);

    // Reset mid-WAIT, then a clean frame
    eng_lat = 5; eng_pat = 8'hFF;
    start(32'h5000_0000, 32'h0400_0000, 32'h0100_0000, 16'd9);
    k = 0;
    while (!frac_go && k < 50) begin
      @(negedge frac_clk); k++;
    end
    check("R_go_seen", 32'(frac_go), 32'd1);
    repeat (2) @(negedge frac_clk);
    @(posedge frac_clk); #1 frac_rst_n = 1'b0;
    @(posedge frac_clk); #1 frac_rst_n = 1'b1;
    @(negedge frac_clk);
    check_reset("rst1");
    start(32'h1234_0000, 32'h0000_0000, 32'h0010_0000, 16'd7);
    wait_frame("C", 400);
    check("C_nwr", 32'(wr_addr.size()), 32'(NPIX));
    check("C_addr0", 32'(wr_addr[0]), 32'd0);
    check("C_cx0", go_cx[0], 32'h1234_0000);
    check("C_cx1", go_cx[1], 32'h1244_0000);
    check("C_cy4", go_cy[4], 32'hFFF0_0000);
    check("C_addr7", 32'(wr_addr[NPIX-1]), 32'(NPIX - 1));
    check("C_mi0", 32'(go_mi[0]), 32'd7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
